// File: rtl/upd7800_bus_pkg.sv
// Shared types and address decode for the uPD7800 bus responder.
// Decode takes the map as arguments so a parameterised top can pass its own.
package upd7800_bus_pkg;

    localparam int          ROM_AW_DEF   = 12;
    localparam logic [15:0] RAM_BASE_DEF = 16'h2000;
    localparam int          RAM_AW_DEF   = 11;

    typedef enum logic [1:0] {PH_CP1P, PH_CP1N, PH_CP2P, PH_CP2N} phase_t;
    typedef enum logic [1:0] {RGN_ROM, RGN_RAM, RGN_NONE} region_t;

    // ROM wins over RAM when both windows cover the address.
    function automatic region_t decode(input logic [15:0] a,
                                       input int          rom_aw   = ROM_AW_DEF,
                                       input logic [15:0] ram_base = RAM_BASE_DEF,
                                       input int          ram_aw   = RAM_AW_DEF);
        region_t rgn;
        rgn = RGN_NONE;
        if ((a >> rom_aw) == 16'd0) begin
            rgn = RGN_ROM;
        end else if ((a >> ram_aw) == (ram_base >> ram_aw)) begin
            rgn = RGN_RAM;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/upd7800_cpgen.sv
// CP1/CP2 edge-strobe generator: a free-running 4-phase counter with registered
// one-hot strobes, frozen at phase 0 while stalled.
module upd7800_cpgen
    import upd7800_bus_pkg::*;
(
    input  logic clk,
    input  logic res,
    input  logic stall,
    output logic cp1_pos,
    output logic cp1_neg,
    output logic cp2_pos,
    output logic cp2_neg
);

    phase_t     ph_q, ph_d;
    logic [3:0] strb_q, strb_d;

    always_comb begin
        ph_d   = ph_q;
        strb_d = strb_q;
        if (res || stall) begin
            ph_d   = PH_CP1P;
            strb_d = 4'b0000;
        end else begin
            strb_d = 4'b0001 << ph_q;
            ph_d   = phase_t'(ph_q + 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        ph_q   <= ph_d;
        strb_q <= strb_d;
    end

    // Stall masks the strobes in the very cycle it is raised, not one later.
    assign cp1_pos = strb_q[0] & ~stall;
    assign cp1_neg = strb_q[1] & ~stall;
    assign cp2_pos = strb_q[2] & ~stall;
    assign cp2_neg = strb_q[3] & ~stall;

endmodule

// File: rtl/upd7800_bus_responder.sv
// Target side of the uPD7800 external bus: CP strobes, boot ROM with host loader,
// work RAM, open-bus read latch and CPU reset release after loading.
module upd7800_bus_responder
    import upd7800_bus_pkg::*;
#(
    parameter int          ROM_AW     = ROM_AW_DEF,
    parameter logic [15:0] RAM_BASE   = RAM_BASE_DEF,
    parameter int          RAM_AW     = RAM_AW_DEF,
    parameter int          RESET_HOLD = 4,
    parameter logic [7:0]  OPEN_BUS   = 8'hFF
) (
    input  logic        CLK,
    input  logic        RES,
    output logic        CP1_POSEDGE,
    output logic        CP1_NEGEDGE,
    output logic        CP2_POSEDGE,
    output logic        CP2_NEGEDGE,
    output logic        CPU_RESETB,
    input  logic [15:0] A,
    input  logic [7:0]  DB_O,
    input  logic        DB_OE,
    output logic [7:0]  DB_I,
    input  logic        LD_ACTIVE,
    input  logic        LD_WR,
    input  logic [15:0] LD_ADDR,
    input  logic [7:0]  LD_DATA
);

    localparam int HOLD_W    = $clog2(RESET_HOLD + 1);
    localparam int ROM_WORDS = 1 << ROM_AW;
    localparam int RAM_WORDS = 1 << RAM_AW;

    logic cp1p, cp1n, cp2p, cp2n;

    upd7800_cpgen u_cpgen (
        .clk     (CLK),
        .res     (RES),
        .stall   (LD_ACTIVE),
        .cp1_pos (cp1p),
        .cp1_neg (cp1n),
        .cp2_pos (cp2p),
        .cp2_neg (cp2n)
    );

    assign CP1_POSEDGE = cp1p;
    assign CP1_NEGEDGE = cp1n;
    assign CP2_POSEDGE = cp2p;
    assign CP2_NEGEDGE = cp2n;

    region_t a_rgn;
    logic    rom_we, ram_we;

    assign a_rgn  = decode(A, ROM_AW, RAM_BASE, RAM_AW);
    assign rom_we = LD_ACTIVE && LD_WR && ((LD_ADDR >> ROM_AW) == 16'd0);
    assign ram_we = cp2n && DB_OE && (a_rgn == RGN_RAM);

    logic [7:0] rom_mem [ROM_WORDS];
    logic [7:0] ram_mem [RAM_WORDS];
    logic [7:0] rom_rd_q, ram_rd_q;

    // Both arrays are read at the CP1P edge; RAM writes land at CP2N, so a
    // read in the following bus cycle already sees the new byte.
    always_ff @(posedge CLK) begin
        if (rom_we) begin
            rom_mem[LD_ADDR[ROM_AW-1:0]] <= LD_DATA;
        end
        if (cp1p) begin
            rom_rd_q <= rom_mem[A[ROM_AW-1:0]];
        end
    end

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram_mem[A[RAM_AW-1:0]] <= DB_O;
        end
        if (cp1p) begin
            ram_rd_q <= ram_mem[A[RAM_AW-1:0]];
        end
    end

    region_t           rd_rgn_q, rd_rgn_d;
    logic              rd_pend_q, rd_pend_d;
    logic [7:0]        db_q, db_d, rd_data;
    logic              rd_hit;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              resetb_q, resetb_d;

    always_comb begin
        rd_pend_d = cp1p;
        rd_rgn_d  = a_rgn;
        rd_data   = (rd_rgn_q == RGN_ROM) ? rom_rd_q : ram_rd_q;
        rd_hit    = rd_pend_q && (rd_rgn_q != RGN_NONE);

        // Unmapped reads leave the latch alone; any driven write refreshes it.
        db_d = db_q;
        if (rd_hit) begin
            db_d = rd_data;
        end
        if (cp2n && DB_OE) begin
            db_d = DB_O;
        end

        hold_d = hold_q;
        if (RES || LD_ACTIVE) begin
            hold_d = HOLD_W'(RESET_HOLD);
        end else if (cp2n && (hold_q != '0)) begin
            hold_d = hold_q - HOLD_W'(1);
        end

        resetb_d = !RES && !LD_ACTIVE && (hold_q == '0);
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            rd_pend_q <= 1'b0;
            rd_rgn_q  <= RGN_NONE;
            db_q      <= OPEN_BUS;
            hold_q    <= HOLD_W'(RESET_HOLD);
            resetb_q  <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_rgn_q  <= rd_rgn_d;
            db_q      <= db_d;
            hold_q    <= hold_d;
            resetb_q  <= resetb_d;
        end
    end

    // Fresh read data is forwarded in the CP1N cycle, then held by db_q.
    assign DB_I       = rd_hit ? rd_data : db_q;
    assign CPU_RESETB = resetb_q;

endmodule

// File: tb/tb_upd7800_bus_responder.sv
// Directed + random bench for upd7800_bus_responder with a cycle-count based
// reference model (phase = cycles since release mod 4, byte arrays for ROM/RAM).
module tb_upd7800_bus_responder;

    localparam int         RESET_HOLD = 4;
    localparam logic [7:0] OPEN_BUS   = 8'hFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res, ld_active, ld_wr, db_oe;
    logic [15:0] a, ld_addr;
    logic [7:0]  db_o, ld_data;
    logic        cp1p, cp1n, cp2p, cp2n, cpu_resetb;
    logic [7:0]  db_i;

    upd7800_bus_responder dut (
        .CLK         (clk),
        .RES         (res),
        .CP1_POSEDGE (cp1p),
        .CP1_NEGEDGE (cp1n),
        .CP2_POSEDGE (cp2p),
        .CP2_NEGEDGE (cp2n),
        .CPU_RESETB  (cpu_resetb),
        .A           (a),
        .DB_O        (db_o),
        .DB_OE       (db_oe),
        .DB_I        (db_i),
        .LD_ACTIVE   (ld_active),
        .LD_WR       (ld_wr),
        .LD_ADDR     (ld_addr),
        .LD_DATA     (ld_data)
    );

    logic [7:0] rom_m [4096];
    logic [7:0] ram_m [2048];
    int         run_cnt = 0;
    logic [7:0] exp_db  = OPEN_BUS;
    int         checks  = 0;
    int         errors  = 0;

    function automatic bit in_ram(input logic [15:0] x);
        return (x >> 11) == (16'h2000 >> 11);
    endfunction

    // Advance one clock and apply to the model what the DUT sampled at that edge.
    task automatic clk_step();
        bit pact;
        int pph;
        @(posedge clk);
        pact = !ld_active && (run_cnt >= 1);
        pph  = (run_cnt - 1) % 4;
        if (res) begin
            run_cnt = 0;
            exp_db  = OPEN_BUS;
        end else begin
            if (ld_active && ld_wr && (ld_addr < 16'h1000)) rom_m[ld_addr[11:0]] = ld_data;
            if (pact && pph == 3 && db_oe) begin
                if (in_ram(a)) ram_m[a[10:0]] = db_o;
                exp_db = db_o;
            end
            if (pact && pph == 0) begin
                if (a < 16'h1000) exp_db = rom_m[a[11:0]];
                else if (in_ram(a)) exp_db = ram_m[a[10:0]];
            end
            run_cnt = ld_active ? 0 : run_cnt + 1;
        end
        #1;
    endtask

    task automatic check(input string tag);
        logic [3:0] exp_s, got_s;
        logic       exp_rb;
        #3;
        exp_s  = (ld_active || run_cnt < 1) ? 4'b0000 : 4'(4'b0001 << ((run_cnt - 1) % 4));
        got_s  = {cp2n, cp2p, cp1n, cp1p};
        exp_rb = (run_cnt >= 4 * RESET_HOLD + 2);
        checks++;
        assert (got_s === exp_s) else begin
            errors++;
            $error("FAIL %s strobes got=%b exp=%b", tag, got_s, exp_s);
        end
        checks++;
        assert (cpu_resetb === exp_rb) else begin
            errors++;
            $error("FAIL %s cpu_resetb got=%b exp=%b (run_cnt=%0d)", tag, cpu_resetb, exp_rb, run_cnt);
        end
        checks++;
        assert (db_i === exp_db) else begin
            errors++;
            $error("FAIL %s db_i got=%h exp=%h", tag, db_i, exp_db);
        end
    endtask

    // One full bus cycle: address in CP1P, optional write in CP2N, stray OE in CP1N.
    task automatic bus_op(input logic [15:0] addr, input bit we, input logic [7:0] wd,
                          input string tag);
        int guard;
        guard = 0;
        clk_step();
        db_oe = 1'b0;
        ld_wr = 1'b0;
        while (((run_cnt % 4) != 1 || ld_active) && guard < 16) begin
            check(tag);
            clk_step();
            guard++;
        end
        checks++;
        assert (guard < 16) else begin
            errors++;
            $error("FAIL %s align got=%0d limit=16", tag, guard);
        end
        a = addr;
        check(tag);
        clk_step();
        db_oe = 1'($urandom_range(0, 1));
        db_o  = 8'($urandom);
        check(tag);
        clk_step();
        db_oe = 1'b0;
        check(tag);
        clk_step();
        db_oe = we;
        db_o  = wd;
        check(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            clk_step();
            db_oe = 1'b0;
            check(tag);
        end
    endtask

    int          kind, guard;
    logic [15:0] ad;
    logic [7:0]  d;

    initial begin
        res = 1'b1; ld_active = 1'b0; ld_wr = 1'b0; db_oe = 1'b0;
        a = 16'h0; ld_addr = 16'h0; db_o = 8'h0; ld_data = 8'h0;

        idle(3, "reset");
        clk_step(); res = 1'b0; check("release");
        idle(8, "idle_order");

        bus_op(16'h8000, 1'b0, 8'h00, "first_open_bus");

        // Host load of ROM bytes 0x00..0xFF, plus one out-of-range write.
        clk_step();
        ld_active = 1'b1; ld_wr = 1'b1; ld_addr = 16'h0000; ld_data = 8'h00;
        check("load");
        for (int i = 1; i < 256; i++) begin
            clk_step();
            ld_addr = 16'(i); ld_data = 8'(i);
            check("load");
        end
        clk_step(); ld_addr = 16'h1005; ld_data = 8'hEE; check("load_oob");
        clk_step(); ld_wr = 1'b0; ld_active = 1'b0; check("load_end");
        idle(4 * RESET_HOLD + 3, "resetb_release");

        bus_op(16'h0010, 1'b0, 8'h00, "rom_rd_10");

        for (int i = 0; i < 32; i++) begin
            bus_op(16'h2000 + 16'(i), 1'b1, 8'($urandom), "ram_init");
            bus_op(16'h27E0 + 16'(i), 1'b1, 8'($urandom), "ram_init");
        end

        bus_op(16'h2005, 1'b1, 8'hA5, "ram_wr_a5");
        bus_op(16'h2005, 1'b0, 8'h00, "ram_rd_a5");
        bus_op(16'h0005, 1'b1, 8'h5A, "rom_wr_5a");
        bus_op(16'h0005, 1'b0, 8'h00, "rom_rd_05");
        bus_op(16'h2003, 1'b1, 8'h3C, "wr_3c");
        bus_op(16'h8000, 1'b0, 8'h00, "open_bus_3c");

        // LD_WR without LD_ACTIVE must not touch ROM.
        clk_step(); db_oe = 1'b0; ld_wr = 1'b1; ld_addr = 16'h0006; ld_data = 8'hEE;
        check("ldwr_idle");
        bus_op(16'h0006, 1'b0, 8'h00, "rom_rd_06");

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 5);
            d    = 8'($urandom);
            case (kind)
                0: bus_op(16'($urandom_range(0, 255)), 1'b0, d, "rnd_rom_rd");
                1: bus_op(16'($urandom_range(0, 255)), 1'b1, d, "rnd_rom_wr");
                2, 3: begin
                    ad = ($urandom_range(0, 1) == 1) ? 16'h2000 : 16'h27E0;
                    ad = ad + 16'($urandom_range(0, 31));
                    bus_op(ad, kind == 3, d, "rnd_ram");
                end
                default: begin
                    case ($urandom_range(0, 2))
                        0:       ad = 16'h1000 + 16'($urandom_range(0, 4095));
                        1:       ad = 16'h2800 + 16'($urandom_range(0, 2047));
                        default: ad = 16'h8000 | 16'($urandom_range(0, 32767));
                    endcase
                    bus_op(ad, kind == 5, d, "rnd_unmapped");
                end
            endcase
        end

        // Raise LD_ACTIVE in a CP2P cycle.
        guard = 0;
        clk_step(); db_oe = 1'b0;
        while ((run_cnt % 4) != 3 && guard < 8) begin
            check("seek_ph2");
            clk_step();
            guard++;
        end
        ld_active = 1'b1;
        check("stall_same_clk");
        idle(5, "stall_hold");
        clk_step(); ld_active = 1'b0; check("stall_end");
        idle(4 * RESET_HOLD + 3, "restart");
        for (int i = 0; i < 8; i++) begin
            ad = (i < 4) ? 16'h2000 + 16'($urandom_range(0, 31)) : 16'h27E0 + 16'($urandom_range(0, 31));
            bus_op(ad, 1'b0, 8'h00, "ram_after_stall");
        end
        bus_op(16'h2005, 1'b0, 8'h00, "ram_after_stall");

        // Second reset: memories survive, bus latch returns to OPEN_BUS.
        clk_step(); db_oe = 1'b0; res = 1'b1; check("reset2");
        clk_step(); check("reset2");
        clk_step(); res = 1'b0; check("reset2_release");
        idle(2, "reset2_idle");
        bus_op(16'h0010, 1'b0, 8'h00, "rom_after_reset");
        bus_op(16'h2003, 1'b0, 8'h00, "ram_after_reset");
        idle(4, "tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
